// File: rtl/lsu_axi_param.sv
// lsu_axi_param: single-beat AXI4 load/store unit between execute and the data-side AXI4 master port.
// Latency: 1 cycle after accept for locally resolved requests, otherwise 1 cycle after the final AXI handshake.
// Backpressure: o_ready is high only in IDLE (one transaction in flight); AXI channels use plain valid/ready.
// Optional: define LSU_TIMEOUT_EN to abort a stalled bus transaction after TIMEOUT wait cycles (code 11).
module lsu_axi_param #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 4,
  parameter int AXI_ID  = 0,
  parameter int TIMEOUT = 255
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  // request side
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_ren,
  input  logic                  i_wen,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [31:0]           i_wdata,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  // completion side
  output logic                  o_valid,
  output logic [31:0]           o_rdata,
  output logic                  o_err,
  output logic [1:0]            o_err_code,
  // AR channel
  output logic [ADDR_W-1:0]     o_axi_araddr,
  output logic                  o_axi_arvalid,
  input  logic                  i_axi_arready,
  output logic [ID_W-1:0]       o_axi_arid,
  output logic [7:0]            o_axi_arlen,
  output logic [2:0]            o_axi_arsize,
  output logic [1:0]            o_axi_arburst,
  // R channel
  input  logic [DATA_W-1:0]     i_axi_rdata,
  input  logic                  i_axi_rvalid,
  input  logic [1:0]            i_axi_rresp,
  input  logic                  i_axi_rlast,
  input  logic [ID_W-1:0]       i_axi_rid,
  output logic                  o_axi_rready,
  // AW channel
  output logic [ADDR_W-1:0]     o_axi_awaddr,
  output logic                  o_axi_awvalid,
  input  logic                  i_axi_awready,
  output logic [ID_W-1:0]       o_axi_awid,
  output logic [7:0]            o_axi_awlen,
  output logic [2:0]            o_axi_awsize,
  output logic [1:0]            o_axi_awburst,
  // W channel
  output logic [DATA_W-1:0]     o_axi_wdata,
  output logic [DATA_W/8-1:0]   o_axi_wstrb,
  output logic                  o_axi_wvalid,
  input  logic                  i_axi_wready,
  output logic                  o_axi_wlast,
  // B channel
  input  logic [1:0]            i_axi_bresp,
  input  logic                  i_axi_bvalid,
  input  logic [ID_W-1:0]       i_axi_bid,
  output logic                  o_axi_bready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int REP    = DATA_W / 32;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_MIS  = 2'b01;
  localparam logic [1:0] CODE_BUS  = 2'b10;
  localparam logic [1:0] CODE_ILL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RADDR,
    S_RDATA,
    S_WREQ,
    S_WRESP,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic                r_ren;
  logic                r_wen;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_bready;
  logic                r_valid;
  logic                r_err;
  logic [1:0]          r_err_code;
  logic [31:0]         r_rdata;

  // ---------------------------------------------------------------------------
  // Load path: move the addressed bytes down to bit 0, then extend.
  // ---------------------------------------------------------------------------
  logic [OFF_W+2:0]    w_lane_shift;
  logic [DATA_W-1:0]   w_rbeat;
  logic [31:0]         w_rlow;
  logic [31:0]         w_rext;

  assign w_lane_shift = {r_addr[OFF_W-1:0], 3'b000};
  assign w_rbeat      = i_axi_rdata >> w_lane_shift;
  assign w_rlow       = w_rbeat[31:0];

  // Sign- or zero-extend the aligned beat according to the latched size.
  always_comb begin
    w_rext = w_rlow;
    case (r_size)
      2'd0:    w_rext = {{24{~r_unsigned & w_rlow[7]}},  w_rlow[7:0]};
      2'd1:    w_rext = {{16{~r_unsigned & w_rlow[15]}}, w_rlow[15:0]};
      default: w_rext = w_rlow;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Store path: the word is replicated so every 32-bit half of a wide bus
  // carries it, then rotated into place within the word; strobes pick lanes.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0]   w_wrep;
  logic [DATA_W-1:0]   w_wbus;
  logic [STRB_W-1:0]   w_strb_base;
  logic [STRB_W-1:0]   w_strb;

  assign w_wrep = {REP{r_wdata}};
  assign w_wbus = w_wrep << {r_addr[1:0], 3'b000};

  // Unshifted byte-enable pattern for the access size.
  always_comb begin
    w_strb_base = STRB_W'(4'b1111);
    case (r_size)
      2'd0:    w_strb_base = STRB_W'(4'b0001);
      2'd1:    w_strb_base = STRB_W'(4'b0011);
      default: w_strb_base = STRB_W'(4'b1111);
    endcase
  end

  assign w_strb = w_strb_base << r_addr[OFF_W-1:0];

  // ---------------------------------------------------------------------------
  // Request classification (evaluated on the live inputs at accept).
  // ---------------------------------------------------------------------------
  logic w_accept;
  logic w_illegal;
  logic w_misaligned;
  logic w_aw_pend;
  logic w_w_pend;

  assign w_accept     = i_valid && (r_state == S_IDLE);
  assign w_illegal    = (i_ren && i_wen) || (i_size == 2'd3);
  assign w_misaligned = ((i_size == 2'd1) && i_addr[0]) ||
                        ((i_size == 2'd2) && (i_addr[1:0] != 2'b00));

  // AW and W each stay pending until their own handshake completes.
  assign w_aw_pend = r_awvalid && !i_axi_awready;
  assign w_w_pend  = r_wvalid  && !i_axi_wready;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             w_waiting;
  logic             w_tmo_hit;

  assign w_waiting = (r_state == S_RADDR) || (r_state == S_RDATA) ||
                     (r_state == S_WREQ)  || (r_state == S_WRESP);
  // The increment taking place this cycle is the one that reaches TIMEOUT.
  assign w_tmo_hit = w_waiting && (r_tmo_cnt == TMO_LAST);
`endif

  // Main controller: state, AXI valids/readies and the completion pulse.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_ren      <= 1'b0;
      r_wen      <= 1'b0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= CODE_NONE;
      r_rdata    <= '0;
`ifdef LSU_TIMEOUT_EN
      r_tmo_cnt  <= '0;
`endif
    end else begin
      // Completion flags are single-cycle; only the RESP entry raises them.
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= CODE_NONE;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr     <= i_addr;
            r_wdata    <= i_wdata;
            r_size     <= i_size;
            r_unsigned <= i_unsigned;
            r_ren      <= i_ren;
            r_wen      <= i_wen;
`ifdef LSU_TIMEOUT_EN
            r_tmo_cnt  <= '0;
`endif
            if (w_illegal) begin
              r_state    <= S_RESP;
              r_valid    <= 1'b1;
              r_err      <= 1'b1;
              r_err_code <= CODE_ILL;
            end else if (w_misaligned) begin
              r_state    <= S_RESP;
              r_valid    <= 1'b1;
              r_err      <= 1'b1;
              r_err_code <= CODE_MIS;
            end else if (i_ren) begin
              r_state   <= S_RADDR;
              r_arvalid <= 1'b1;
            end else if (i_wen) begin
              r_state   <= S_WREQ;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              // Nothing to do: acknowledge cleanly.
              r_state <= S_RESP;
              r_valid <= 1'b1;
            end
          end
        end

        S_RADDR: begin
          if (i_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RDATA;
          end
        end

        S_RDATA: begin
          if (i_axi_rvalid) begin
            // Data is captured even on an error response.
            r_rready   <= 1'b0;
            r_rdata    <= w_rext;
            r_state    <= S_RESP;
            r_valid    <= 1'b1;
            r_err      <= i_axi_rresp[1];
            r_err_code <= i_axi_rresp[1] ? CODE_BUS : CODE_NONE;
          end
        end

        S_WREQ: begin
          r_awvalid <= w_aw_pend;
          r_wvalid  <= w_w_pend;
          if (!w_aw_pend && !w_w_pend) begin
            r_bready <= 1'b1;
            r_state  <= S_WRESP;
          end
        end

        S_WRESP: begin
          if (i_axi_bvalid) begin
            r_bready   <= 1'b0;
            r_state    <= S_RESP;
            r_valid    <= 1'b1;
            r_err      <= i_axi_bresp[1];
            r_err_code <= i_axi_bresp[1] ? CODE_BUS : CODE_NONE;
          end
        end

        S_RESP: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase

`ifdef LSU_TIMEOUT_EN
      // Abort overrides whatever the wait state decided this cycle.
      if (w_tmo_hit) begin
        r_arvalid  <= 1'b0;
        r_rready   <= 1'b0;
        r_awvalid  <= 1'b0;
        r_wvalid   <= 1'b0;
        r_bready   <= 1'b0;
        r_state    <= S_RESP;
        r_valid    <= 1'b1;
        r_err      <= 1'b1;
        r_err_code <= CODE_ILL;
      end else if (w_waiting) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
`endif
    end
  end

  // Request/completion outputs.
  assign o_ready    = (r_state == S_IDLE);
  assign o_valid    = r_valid;
  assign o_rdata    = r_rdata;
  assign o_err      = r_err;
  assign o_err_code = r_err_code;

  // AR channel.
  assign o_axi_araddr  = r_addr;
  assign o_axi_arvalid = r_arvalid;
  assign o_axi_arid    = ID_W'(AXI_ID);
  assign o_axi_arlen   = 8'd0;
  assign o_axi_arsize  = {1'b0, r_size};
  assign o_axi_arburst = 2'b01;

  // R channel.
  assign o_axi_rready = r_rready;

  // AW channel.
  assign o_axi_awaddr  = r_addr;
  assign o_axi_awvalid = r_awvalid;
  assign o_axi_awid    = ID_W'(AXI_ID);
  assign o_axi_awlen   = 8'd0;
  assign o_axi_awsize  = {1'b0, r_size};
  assign o_axi_awburst = 2'b01;

  // W channel.
  assign o_axi_wdata  = w_wbus;
  assign o_axi_wstrb  = w_strb;
  assign o_axi_wvalid = r_wvalid;
  assign o_axi_wlast  = 1'b1;

  // B channel.
  assign o_axi_bready = r_bready;

  // IDs, rlast and the low response bit carry nothing this unit acts on.
  logic w_unused;
  assign w_unused = ^{1'b0, i_axi_rresp[0], i_axi_rlast, i_axi_rid,
                      i_axi_bresp[0], i_axi_bid, r_ren, r_wen, 32'(TIMEOUT)};

endmodule

// File: tb/tb_lsu_axi_param.sv
// tb_lsu_axi_param: directed bench driving a 32-bit and a 64-bit bus instance in lockstep.
// Both instances share request and handshake inputs; each gets its own read beat.
// Expected values are hand-computed per vector.
module tb_lsu_axi_param;

  localparam int ID_W   = 4;
  localparam int AXI_ID = 3;
`ifdef LSU_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 255;
`endif

  logic        clk;
  logic        rst;
  logic        i_valid, i_ren, i_wen, i_unsigned;
  logic [31:0] i_addr, i_wdata;
  logic [1:0]  i_size;
  logic        arready, rvalid, rlast, awready, wready, bvalid;
  logic [1:0]  rresp, bresp;
  logic [ID_W-1:0] rid, bid;
  logic [31:0] rdata32;
  logic [63:0] rdata64;

  // 32-bit instance outputs
  logic a_ready, a_valid, a_err;
  logic [1:0] a_code;
  logic [31:0] a_rdata, a_araddr, a_awaddr, a_wdata;
  logic a_arvalid, a_rready, a_awvalid, a_wvalid, a_wlast, a_bready;
  logic [ID_W-1:0] a_arid, a_awid;
  logic [7:0] a_arlen, a_awlen;
  logic [2:0] a_arsize, a_awsize;
  logic [1:0] a_arburst, a_awburst;
  logic [3:0] a_wstrb;

  // 64-bit instance outputs
  logic b_ready, b_valid, b_err;
  logic [1:0] b_code;
  logic [31:0] b_rdata, b_araddr, b_awaddr;
  logic [63:0] b_wdata;
  logic b_arvalid, b_rready, b_awvalid, b_wvalid, b_wlast, b_bready;
  logic [ID_W-1:0] b_arid, b_awid;
  logic [7:0] b_arlen, b_awlen;
  logic [2:0] b_arsize, b_awsize;
  logic [1:0] b_arburst, b_awburst;
  logic [7:0] b_wstrb;

  int n_chk  = 0;
  int n_fail = 0;

  lsu_axi_param #(.ADDR_W(32), .DATA_W(32), .ID_W(ID_W), .AXI_ID(AXI_ID), .TIMEOUT(TMO)) u_dut32 (
    .i_clock(clk), .i_reset(rst),
    .i_valid(i_valid), .o_ready(a_ready), .i_ren(i_ren), .i_wen(i_wen),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_size(i_size), .i_unsigned(i_unsigned),
    .o_valid(a_valid), .o_rdata(a_rdata), .o_err(a_err), .o_err_code(a_code),
    .o_axi_araddr(a_araddr), .o_axi_arvalid(a_arvalid), .i_axi_arready(arready),
    .o_axi_arid(a_arid), .o_axi_arlen(a_arlen), .o_axi_arsize(a_arsize), .o_axi_arburst(a_arburst),
    .i_axi_rdata(rdata32), .i_axi_rvalid(rvalid), .i_axi_rresp(rresp), .i_axi_rlast(rlast),
    .i_axi_rid(rid), .o_axi_rready(a_rready),
    .o_axi_awaddr(a_awaddr), .o_axi_awvalid(a_awvalid), .i_axi_awready(awready),
    .o_axi_awid(a_awid), .o_axi_awlen(a_awlen), .o_axi_awsize(a_awsize), .o_axi_awburst(a_awburst),
    .o_axi_wdata(a_wdata), .o_axi_wstrb(a_wstrb), .o_axi_wvalid(a_wvalid), .i_axi_wready(wready),
    .o_axi_wlast(a_wlast),
    .i_axi_bresp(bresp), .i_axi_bvalid(bvalid), .i_axi_bid(bid), .o_axi_bready(a_bready)
  );

  lsu_axi_param #(.ADDR_W(32), .DATA_W(64), .ID_W(ID_W), .AXI_ID(AXI_ID), .TIMEOUT(TMO)) u_dut64 (
    .i_clock(clk), .i_reset(rst),
    .i_valid(i_valid), .o_ready(b_ready), .i_ren(i_ren), .i_wen(i_wen),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_size(i_size), .i_unsigned(i_unsigned),
    .o_valid(b_valid), .o_rdata(b_rdata), .o_err(b_err), .o_err_code(b_code),
    .o_axi_araddr(b_araddr), .o_axi_arvalid(b_arvalid), .i_axi_arready(arready),
    .o_axi_arid(b_arid), .o_axi_arlen(b_arlen), .o_axi_arsize(b_arsize), .o_axi_arburst(b_arburst),
    .i_axi_rdata(rdata64), .i_axi_rvalid(rvalid), .i_axi_rresp(rresp), .i_axi_rlast(rlast),
    .i_axi_rid(rid), .o_axi_rready(b_rready),
    .o_axi_awaddr(b_awaddr), .o_axi_awvalid(b_awvalid), .i_axi_awready(awready),
    .o_axi_awid(b_awid), .o_axi_awlen(b_awlen), .o_axi_awsize(b_awsize), .o_axi_awburst(b_awburst),
    .o_axi_wdata(b_wdata), .o_axi_wstrb(b_wstrb), .o_axi_wvalid(b_wvalid), .i_axi_wready(wready),
    .o_axi_wlast(b_wlast),
    .i_axi_bresp(bresp), .i_axi_bvalid(bvalid), .i_axi_bid(bid), .o_axi_bready(b_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, want);
    end
  endtask

  // Present one request for a single cycle; returns at the negedge after accept.
  task automatic issue(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns);
    chk("ready_idle", {a_ready, b_ready}, 2'b11);
    i_valid = 1'b1; i_ren = ren; i_wen = wen; i_addr = addr;
    i_wdata = wdata; i_size = size; i_unsigned = uns;
    @(negedge clk);
    i_valid = 1'b0; i_ren = 1'b0; i_wen = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input int ar_dly, input logic [31:0] rd32,
                         input logic [63:0] rd64, input logic [1:0] resp,
                         input logic [31:0] want, input logic [1:0] code);
    issue(1'b1, 1'b0, addr, 32'h0, size, uns);
    chk({tag, "_arvalid"}, {a_arvalid, b_arvalid}, 2'b11);
    chk({tag, "_araddr"}, a_araddr, addr);
    chk({tag, "_arsize"}, {a_arsize, b_arsize}, {1'b0, size, 1'b0, size});
    chk({tag, "_noready"}, {a_ready, a_rready}, 2'b00);
    repeat (ar_dly) @(negedge clk);
    chk({tag, "_arhold"}, a_arvalid, 1'b1);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk({tag, "_ardrop"}, {a_arvalid, b_arvalid}, 2'b00);
    chk({tag, "_rready"}, {a_rready, b_rready}, 2'b11);
    rvalid = 1'b1; rdata32 = rd32; rdata64 = rd64; rresp = resp;
    @(negedge clk);
    rvalid = 1'b0; rresp = 2'b00;
    chk({tag, "_ovalid"}, {a_valid, b_valid, a_rready}, 3'b110);
    chk({tag, "_rdata32"}, a_rdata, want);
    chk({tag, "_rdata64"}, b_rdata, want);
    chk({tag, "_code"}, {a_err, a_code, b_err, b_code}, {code != 2'b00, code, code != 2'b00, code});
    @(negedge clk);
    chk({tag, "_pulse"}, {a_valid, b_valid, a_ready}, 3'b001);
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] size, input int aw_dly, input int w_dly,
                          input logic [1:0] resp, input logic [3:0] strb32,
                          input logic [31:0] wd32, input logic [7:0] strb64,
                          input logic [63:0] wd64, input logic [1:0] code);
    int mx;
    mx = (aw_dly > w_dly) ? aw_dly : w_dly;
    issue(1'b0, 1'b1, addr, wd, size, 1'b0);
    chk({tag, "_vld"}, {a_awvalid, a_wvalid, b_awvalid, b_wvalid, a_arvalid}, 5'b11110);
    chk({tag, "_strb32"}, a_wstrb, strb32);
    chk({tag, "_wdata32"}, a_wdata, wd32);
    chk({tag, "_strb64"}, b_wstrb, strb64);
    chk({tag, "_wdata64"}, b_wdata, wd64);
    chk({tag, "_aw"}, {a_awaddr, a_awsize, a_awlen, a_awburst, a_awid, a_wlast},
        {addr, 1'b0, size, 8'd0, 2'b01, 4'(AXI_ID), 1'b1});
    chk({tag, "_aw64"}, {b_awaddr, b_awsize, b_awlen, b_awburst, b_awid, b_wlast},
        {addr, 1'b0, size, 8'd0, 2'b01, 4'(AXI_ID), 1'b1});
    for (int c = 0; c <= mx; c++) begin
      awready = (c == aw_dly);
      wready  = (c == w_dly);
      @(negedge clk);
      chk({tag, "_hs"}, {a_awvalid, a_wvalid, a_bready, b_bready},
          {c < aw_dly, c < w_dly, c >= mx, c >= mx});
    end
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bresp = resp;
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
    chk({tag, "_ovalid"}, {a_valid, b_valid, a_bready}, 3'b110);
    chk({tag, "_code"}, {a_err, a_code, b_err, b_code}, {code != 2'b00, code, code != 2'b00, code});
    @(negedge clk);
    chk({tag, "_pulse"}, {a_valid, a_ready}, 2'b01);
  endtask

  // Requests resolved without bus traffic.
  task automatic do_imm(input string tag, input logic ren, input logic wen,
                        input logic [31:0] addr, input logic [1:0] size, input logic [1:0] code);
    issue(ren, wen, addr, 32'h5555_AAAA, size, 1'b0);
    chk({tag, "_ovalid"}, {a_valid, b_valid}, 2'b11);
    chk({tag, "_code"}, {a_err, a_code, b_err, b_code}, {code != 2'b00, code, code != 2'b00, code});
    chk({tag, "_nobus"}, {a_arvalid, a_awvalid, a_wvalid, b_arvalid, b_awvalid}, 5'b0);
    @(negedge clk);
    chk({tag, "_pulse"}, {a_valid, a_ready, a_arvalid}, 3'b010);
  endtask

  initial begin
    logic seen;
    rst = 1'b1; i_valid = 1'b0; i_ren = 1'b0; i_wen = 1'b0; i_unsigned = 1'b0;
    i_addr = '0; i_wdata = '0; i_size = '0;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b1; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    rresp = '0; bresp = '0; rid = '0; bid = '0; rdata32 = '0; rdata64 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_ready", {a_ready, b_ready}, 2'b11);
    chk("rst_valids", {a_arvalid, a_awvalid, a_wvalid, a_rready, a_bready, a_valid, a_err}, 7'b0);
    chk("rst_code_rdata", {a_code, a_rdata, b_code, b_rdata}, 68'h0);

    // loads
    do_load("ld_word", 32'h100, 2'd2, 1'b0, 3, 32'hDEADBEEF, 64'h0000_0000_DEAD_BEEF,
            2'b00, 32'hDEADBEEF, 2'b00);
    chk("ar_const", {a_arlen, a_arburst, a_arid, b_arlen, b_arburst, b_arid, b_araddr},
        {8'd0, 2'b01, 4'(AXI_ID), 8'd0, 2'b01, 4'(AXI_ID), 32'h100});
    do_load("ld_sbyte", 32'h103, 2'd0, 1'b0, 0, 32'h80112233, 64'h0000_0000_8011_2233,
            2'b00, 32'hFFFFFF80, 2'b00);
    do_load("ld_uhalf", 32'h106, 2'd1, 1'b1, 0, 32'hABCD0000, 64'hABCD_0000_0000_0000,
            2'b00, 32'h0000ABCD, 2'b00);
    do_load("ld_shalf", 32'h106, 2'd1, 1'b0, 1, 32'hABCD0000, 64'hABCD_0000_0000_0000,
            2'b00, 32'hFFFFABCD, 2'b00);
    do_load("ld_buserr", 32'h104, 2'd2, 1'b0, 0, 32'h12345678, 64'h1234_5678_0000_0000,
            2'b10, 32'h12345678, 2'b10);
    do_load("ld_posbyte", 32'h101, 2'd0, 1'b0, 0, 32'h00007F00, 64'h0000_0000_0000_7F00,
            2'b00, 32'h0000007F, 2'b00);

    // stores
    do_store("st_half", 32'h202, 32'h00001234, 2'd1, 0, 2, 2'b00,
             4'b1100, 32'h12340000, 8'h0C, 64'h1234_0000_1234_0000, 2'b00);
    do_store("st_berr", 32'h208, 32'hCAFEF00D, 2'd2, 1, 1, 2'b10,
             4'b1111, 32'hCAFEF00D, 8'h0F, 64'hCAFE_F00D_CAFE_F00D, 2'b10);
    do_store("st_byte", 32'h20D, 32'h123456A5, 2'd0, 2, 0, 2'b00,
             4'b0010, 32'h3456A500, 8'h20, 64'h3456_A512_3456_A500, 2'b00);

    // locally resolved requests; o_rdata must hold the last load result
    do_imm("mis_word", 1'b1, 1'b0, 32'h101, 2'd2, 2'b01);
    chk("rdata_hold", {a_rdata, b_rdata}, {32'h0000007F, 32'h0000007F});
    do_imm("mis_half", 1'b0, 1'b1, 32'h103, 2'd1, 2'b01);
    do_imm("ill_rw", 1'b1, 1'b1, 32'h100, 2'd2, 2'b11);
    do_imm("ill_size", 1'b1, 1'b0, 32'h100, 2'd3, 2'b11);
    do_imm("nop", 1'b0, 1'b0, 32'h100, 2'd2, 2'b00);

    // reset while waiting for read data
    issue(1'b1, 1'b0, 32'h110, 32'h0, 2'd2, 1'b0);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk("mid_rready", a_rready, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_ready", {a_ready, b_ready}, 2'b11);
    chk("mid_valids", {a_arvalid, a_rready, a_awvalid, a_wvalid, a_bready, a_valid, b_rready}, 7'b0);
    chk("mid_rdata", a_rdata, 32'h0);

    // stalled read address channel
    issue(1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0);
`ifdef LSU_TIMEOUT_EN
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen = seen | a_valid;
    end
    chk("tmo_early", {seen, a_arvalid}, 2'b01);
    @(negedge clk);
    chk("tmo_resp", {a_valid, a_err, a_code, a_arvalid, b_valid, b_code}, {4'b1111, 1'b0, 3'b111});
    @(negedge clk);
    chk("tmo_pulse", {a_valid, a_ready}, 2'b01);
`else
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | a_valid | b_valid;
    end
    chk("stall_wait", {seen, a_arvalid, b_arvalid, a_ready}, 4'b0110);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("stall_rst", {a_ready, a_arvalid}, 2'b10);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
